// File: rtl/mvm_pkg.sv
// Shared encodings for the matrix-vector multiply sequencer.
package mvm_pkg;

   localparam int LANE_W      = 8;
   localparam int MAC_LAT_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESULT = 3'd4
   } state_e;

endpackage

// File: rtl/mvm_sequencer.sv
// Streams W columns and x scalars into one vsmac, drains the MAC
// pipeline and hands the accumulated column sum to the layer controller.
module mvm_sequencer
   import mvm_pkg::*;
#(
   parameter int SIZE    = 3,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDR_W:0]          len,
   output logic                     busy,
   output logic                     err,
   output logic                     col_rd_en,
   output logic [ADDR_W-1:0]        col_addr,
   input  logic [LANE_W*SIZE-1:0]   col_data,
   input  logic [LANE_W-1:0]        x_data,
   output logic                     mac_reset,
   output logic                     mac_enable,
   output logic [LANE_W*SIZE-1:0]   mac_a,
   output logic [LANE_W-1:0]        mac_b,
   input  logic [LANE_W*SIZE-1:0]   mac_out,
   output logic [LANE_W*SIZE-1:0]   result,
   output logic                     result_valid,
   input  logic                     result_ready,
   output logic                     done
);

   localparam int LW = ADDR_W + 1;
   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [DW-1:0] DLAST   = DW'(MAC_LAT - 1);

   state_e                   state_q, state_d;
   logic [LW-1:0]            len_q, len_d;
   logic [LW-1:0]            k_q, k_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [DW-1:0]            dcnt_q, dcnt_d;
   logic [LANE_W*SIZE-1:0]   res_q, res_d;
   logic                     rv_q, rv_d;
   logic                     clr;
   logic                     len_ok;
   logic [LW-1:0]            k_nxt;
   logic [LW-1:0]            a_nxt;

   // Counters carry one extra bit so len == DEPTH never wraps.
   assign k_nxt  = k_q + LW'(1);
   assign a_nxt  = {1'b0, addr_q} + LW'(1);
   assign len_ok = (len != '0) && (len <= DEPTH_L);

   assign busy         = (state_q != ST_IDLE);
   assign col_addr     = addr_q;
   assign result       = res_q;
   assign result_valid = rv_q;
   assign mac_reset    = ~reset_n | clr;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      k_d        = k_q;
      addr_d     = addr_q;
      dcnt_d     = dcnt_q;
      res_d      = res_q;
      rv_d       = rv_q;
      clr        = 1'b0;
      err        = 1'b0;
      done       = 1'b0;
      col_rd_en  = 1'b0;
      mac_enable = 1'b0;
      mac_a      = '0;
      mac_b      = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && len_ok) begin
               len_d   = len;
               k_d     = '0;
               addr_d  = '0;
               dcnt_d  = '0;
               state_d = ST_CLEAR;
            end else if (start) begin
               err = 1'b1;
            end
         end
         ST_CLEAR: begin
            clr       = 1'b1;
            col_rd_en = 1'b1;
            if (a_nxt < len_q) addr_d = addr_q + ADDR_W'(1);
            state_d   = ST_STREAM;
         end
         ST_STREAM: begin
            mac_enable = 1'b1;
            mac_a      = col_data;
            mac_b      = x_data;
            col_rd_en  = (k_nxt < len_q);
            if (col_rd_en && (a_nxt < len_q))
               addr_d = addr_q + ADDR_W'(1);
            if (k_nxt == len_q) begin
               dcnt_d  = '0;
               state_d = ST_DRAIN;
            end else begin
               k_d = k_nxt;
            end
         end
         ST_DRAIN: begin
            mac_enable = 1'b1;
            if (dcnt_q == DLAST) begin
               res_d   = mac_out;
               rv_d    = 1'b1;
               state_d = ST_RESULT;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         ST_RESULT: begin
            if (result_ready) begin
               done    = 1'b1;
               rv_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         k_q     <= '0;
         addr_q  <= '0;
         dcnt_q  <= '0;
         res_q   <= '0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         dcnt_q  <= dcnt_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
      end
   end

endmodule

// File: tb/tb_mvm_sequencer.sv
// Bench for mvm_sequencer with a behavioural vsmac and two 1-cycle ROMs.
module tb_mvm_sequencer;

   localparam int SIZE   = 3;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int LAT    = 2;
   localparam int DW     = 8 * SIZE;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   len = '0;
   logic              result_ready = 1'b1;
   logic              busy, err, col_rd_en, mac_reset, mac_enable;
   logic              result_valid, done;
   logic [ADDR_W-1:0] col_addr;
   logic [DW-1:0]     col_data, mac_a, mac_out, result;
   logic [7:0]        x_data, mac_b;

   logic [DW-1:0]     w_mem [DEPTH];
   logic [7:0]        x_mem [DEPTH];
   logic [DW-1:0]     prod_q, acc_q;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int rd_cnt = 0;
   int last_done = -1;
   int last_acc = -1;
   bit m_pend, m_idle, m_rv;

   typedef struct {
      int            acc;
      int            vcyc;
      int            n;
      logic [DW-1:0] res;
   } job_t;
   job_t sb[$];

   mvm_sequencer #(
      .SIZE(SIZE), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAC_LAT(LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .len(len),
      .busy(busy), .err(err), .col_rd_en(col_rd_en),
      .col_addr(col_addr), .col_data(col_data), .x_data(x_data),
      .mac_reset(mac_reset), .mac_enable(mac_enable),
      .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
      .result(result), .result_valid(result_valid),
      .result_ready(result_ready), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (col_rd_en) begin
         col_data <= w_mem[col_addr];
         x_data   <= x_mem[col_addr];
      end
   end

   // vsmac stand-in: lane products registered, then accumulated.
   always @(posedge clk) begin
      if (mac_reset) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else if (mac_enable) begin
         for (int l = 0; l < SIZE; l++) begin
            prod_q[l*8 +: 8] <= mac_a[l*8 +: 8] * mac_b;
            acc_q[l*8 +: 8]  <= acc_q[l*8 +: 8] + prod_q[l*8 +: 8];
         end
      end
   end
   assign mac_out = acc_q;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] ref_mvm(input int n);
      logic [DW-1:0] r;
      r = '0;
      for (int l = 0; l < SIZE; l++) begin
         int s;
         s = 0;
         for (int k = 0; k < n; k++)
            s += int'(w_mem[k][l*8 +: 8]) * int'(x_mem[k]);
         r[l*8 +: 8] = 8'(s);
      end
      return r;
   endfunction

   // Scoreboard monitor: expected busy/valid windows follow the queued job.
   always @(negedge clk) begin
      if (reset_n) begin
         m_pend = (sb.size() > 0);
         m_idle = 1'b1;
         m_rv   = 1'b0;
         if (m_pend) begin
            m_idle = (cyc <= sb[0].acc);
            m_rv   = (cyc >= sb[0].vcyc);
         end
         chk("busy", busy, !m_idle);
         chk("result_valid", result_valid, m_rv);
         chk("err", err, start && m_idle && (len < 1 || len > DEPTH));
         if (m_idle) begin
            chk("rd_idle", col_rd_en, 0);
         end else if (col_rd_en) begin
            chk("col_addr", col_addr, rd_cnt);
            rd_cnt++;
         end
         if (m_rv) begin
            chk("result", result, sb[0].res);
            chk("done", done, result_ready);
            if (result_ready) begin
               chk("reads", rd_cnt, sb[0].n);
               rd_cnt    = 0;
               last_done = cyc;
               void'(sb.pop_front());
            end
         end else begin
            chk("done_idle", done, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int n, input logic [DW-1:0] exp,
                        input bit hold);
      bit   ok;
      job_t j;
      ok    = 1'b0;
      start = 1'b1;
      len   = (ADDR_W+1)'(n);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!busy) begin
            j.acc  = cyc;
            j.vcyc = cyc + n + LAT + 2;
            j.n    = n;
            j.res  = exp;
            sb.push_back(j);
            last_acc = cyc;
            ok = 1'b1;
         end
         tick();
      end
      if (!hold) start = 1'b0;
      chk("accept_timeout", ok, 1);
   endtask

   task automatic wait_idle(input bit rnd);
      for (int i = 0; i < 400 && sb.size() > 0; i++) begin
         result_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      chk("job_timeout", sb.size(), 0);
      if (sb.size() > 0) begin
         sb.delete();
         rd_cnt = 0;
      end
   endtask

   task automatic chk_reset_outs();
      chk("rst_busy", busy, 0);
      chk("rst_rv", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_addr", col_addr, 0);
      chk("rst_rd", col_rd_en, 0);
      chk("rst_en", mac_enable, 0);
      chk("rst_a", mac_a, 0);
      chk("rst_mac_reset", mac_reset, 1);
      chk("rst_done", done, 0);
   endtask

   task automatic load_t1();
      w_mem[0] = 24'h010407;
      w_mem[1] = 24'h020508;
      w_mem[2] = 24'h030609;
      x_mem[0] = 8'h01;
      x_mem[1] = 8'h02;
      x_mem[2] = 8'h03;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int k = 0; k < DEPTH; k++) begin
         w_mem[k] = '0;
         x_mem[k] = '0;
      end
      #12;
      chk_reset_outs();
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      load_t1();
      issue(3, 24'h0E2032, 0);
      wait_idle(0);

      w_mem[0] = 24'hFF0102;
      x_mem[0] = 8'h02;
      issue(1, 24'hFE0204, 0);
      wait_idle(0);

      start = 1'b1;
      len   = 5'd0;
      tick();
      len   = 5'd17;
      tick();
      start = 1'b0;
      tick();
      tick();

      load_t1();
      result_ready = 1'b0;
      issue(3, 24'h0E2032, 0);
      for (int i = 0; i < 100 && !result_valid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         len   = 5'd2;
         tick();
      end
      start = 1'b0;
      wait_idle(0);

      issue(3, 24'h0E2032, 0);
      tick();
      tick();
      chk("t5_rd_k1", col_rd_en, 1);
      chk("t5_addr_k1", col_addr, 2);
      reset_n = 1'b0;
      #1;
      chk_reset_outs();
      sb.delete();
      rd_cnt = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      issue(3, 24'h0E2032, 0);
      wait_idle(0);

      result_ready = 1'b1;
      issue(3, 24'h0E2032, 1);
      len = 5'd2;
      issue(2, 24'h050E17, 0);
      chk("b2b_accept", last_acc, last_done + 1);
      wait_idle(0);

      for (int j = 0; j < 25; j++) begin
         for (int k = 0; k < DEPTH; k++) begin
            w_mem[k] = DW'($urandom);
            x_mem[k] = 8'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            start = 1'b1;
            len   = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd17;
            tick();
            start = 1'b0;
         end
         n = (j == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
         issue(n, ref_mvm(n), 0);
         wait_idle(1);
      end

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
